// File: rtl/io_bridge.sv
// io_bridge: routes CPU data accesses either straight through to the data
// cache or, for the device address regions, through a small request/ack
// sequencer that drives one of NUM_DEV device channels.
//
// Device handshake: while in REQ, dev_req[k] is held high and the command
// fields (dev_we/dev_addr/dev_wdata/dev_be) are held stable. The transfer
// completes on the first ui_clk edge where dev_ack[k] is high, and dev_req
// drops on that same edge. Ack bits of other channels are never looked at.
// If no ack arrives within TIMEOUT REQ cycles, the access completes with
// ERR_DATA and a one-cycle bus_err pulse. TIMEOUT = 0 disables the timeout.
module io_bridge #(
  parameter int          NUM_DEV         = 4,
  parameter logic [3:0]  DEV_REGION_BASE = 4'hc,
  parameter int          TIMEOUT         = 1024,
  parameter logic [31:0] ERR_DATA        = 32'hdeadbeef
) (
  input  logic                   ui_clk,
  input  logic                   rst,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [29:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_be,
  output logic [31:0]            cpu_rdata,
  output logic                   stall,
  output logic                   dc_read,
  output logic                   dc_write,
  input  logic [31:0]            dc_rdata,
  input  logic                   cache_stall,
  output logic [NUM_DEV-1:0]     dev_req,
  output logic                   dev_we,
  output logic [25:0]            dev_addr,
  output logic [31:0]            dev_wdata,
  output logic [3:0]             dev_be,
  input  logic [NUM_DEV-1:0]     dev_ack,
  input  logic [32*NUM_DEV-1:0]  dev_rdata,
  output logic                   bus_err,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter is kept at least 1 bit wide so TIMEOUT = 0 still elaborates.
  localparam int          CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int          TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  // 5-bit region arithmetic so BASE+NUM_DEV = 16 does not wrap.
  localparam logic [4:0] BASE5 = {1'b0, DEV_REGION_BASE};
  localparam logic [4:0] LIM5  = BASE5 + 5'(NUM_DEV);

  state_t              state;
  logic [1:0]          sel_q;
  logic [CW-1:0]       to_cnt;
  logic [31:0]         rd_reg;

  logic [4:0]          region5;
  logic [4:0]          off5;
  logic                is_dev;
  logic                access;
  logic [1:0]          dev_idx;
  logic [NUM_DEV-1:0]  req_onehot;
  logic                ack_hit;
  logic [31:0]         rdata_hit;

  assign state_dbg = state;
  assign region5   = {1'b0, cpu_addr[29:26]};
  assign off5      = region5 - BASE5;
  assign dev_idx   = off5[1:0];
  assign is_dev    = (region5 >= BASE5) && (region5 < LIM5);
  assign access    = cpu_read | cpu_write;

  // Decode the target channel and select the latched channel's ack/data.
  always_comb begin
    req_onehot = '0;
    ack_hit    = 1'b0;
    rdata_hit  = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (dev_idx == 2'(k)) req_onehot[k] = 1'b1;
      if (sel_q == 2'(k)) begin
        ack_hit   = dev_ack[k];
        rdata_hit = dev_rdata[32*k +: 32];
      end
    end
  end

  // Sequencer: latch the device command, wait for ack or timeout, complete.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      dev_req   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
      rd_reg    <= '0;
      to_cnt    <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus_err <= 1'b0;
          if (access && is_dev) begin
            sel_q     <= dev_idx;
            dev_we    <= cpu_write;
            dev_addr  <= cpu_addr[25:0];
            dev_wdata <= cpu_wdata;
            dev_be    <= cpu_be;
            dev_req   <= req_onehot;
            to_cnt    <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_hit) begin
            // Ack wins over a simultaneous timeout.
            if (!dev_we) rd_reg <= rdata_hit;
            dev_req <= '0;
            state   <= S_DONE;
          end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
            rd_reg  <= ERR_DATA;
            bus_err <= 1'b1;
            dev_req <= '0;
            state   <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          bus_err <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          bus_err <= 1'b0;
          dev_req <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // CPU/cache-side outputs: cache pass-through only while idle on a cache region.
  always_comb begin
    dc_read   = 1'b0;
    dc_write  = 1'b0;
    stall     = 1'b1;
    cpu_rdata = '0;
    case (state)
      S_IDLE: begin
        if (access && is_dev) begin
          stall     = 1'b1;
          cpu_rdata = '0;
        end else begin
          dc_read   = cpu_read;
          dc_write  = cpu_write;
          stall     = cache_stall;
          cpu_rdata = dc_rdata;
        end
      end
      S_DONE: begin
        stall     = 1'b0;
        cpu_rdata = rd_reg;
      end
      default: begin
        stall     = 1'b1;
        cpu_rdata = '0;
      end
    endcase
  end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter NUM_DEV, default 4, meaning number of device channels (1..4).
REQ-002 SHALL have parameter DEV_REGION_BASE, default 4'hc, meaning region code of device 0; device k is decoded at region code DEV_REGION_BASE+k.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning REQ-state cycle limit; 0 disables the timeout.
REQ-004 SHALL have parameter ERR_DATA, default 32'hdeadbeef, meaning read data returned on timeout.
REQ-005 SHALL have port ui_clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-low, sampled on ui_clk.
REQ-007 SHALL have ports cpu_read / cpu_write, input, 1 each, the pipeline data access strobes, sampled on ui_clk.
REQ-008 SHALL have ports cpu_addr, input, 30, word address; region code = cpu_addr[29:26].
REQ-009 SHALL have ports cpu_wdata (input, 32), cpu_be (input, 4), cpu_rdata (output, 32) and stall (output, 1).
REQ-010 SHALL have cache-side ports dc_read (output, 1), dc_write (output, 1), dc_rdata (input, 32) and cache_stall (input, 1).
REQ-011 SHALL have device-side ports:
- dev_req, output, NUM_DEV;
- dev_we, output, 1;
- dev_addr, output, 26;
- dev_wdata, output, 32;
- dev_be, output, 4;
- dev_ack, input, NUM_DEV;
- dev_rdata, input, 32*NUM_DEV, with channel k at bits [32k+31:32k].
REQ-012 SHALL have port bus_err, output, 1, a one-cycle pulse on timeout.

Function
REQ-013 Region code below DEV_REGION_BASE, or at/above DEV_REGION_BASE+NUM_DEV, SHALL be the cache path; otherwise it is device k = region - DEV_REGION_BASE.
REQ-014 Cache path, FSM in IDLE: combinational pass-through:
- dc_read = cpu_read, dc_write = cpu_write;
- cpu_rdata = dc_rdata, stall = cache_stall.
REQ-015 In any non-IDLE state, dc_read and dc_write SHALL be 0.
REQ-016 FSM states SHALL be IDLE, REQ and DONE, encoded in 2 bits.
REQ-017 IDLE with (cpu_read|cpu_write) and a device region: stall SHALL be asserted combinationally in that same cycle.
- At the next edge: latch k, we = cpu_write, cpu_addr[25:0], cpu_wdata and cpu_be; go to REQ.
REQ-018 When both cpu_read and cpu_write are high, the access SHALL be treated as a write.
REQ-019 REQ: dev_req[k] SHALL be 1 (registered; all other bits 0) and dev_we/dev_addr/dev_wdata/dev_be SHALL drive the latched values, held stable; stall SHALL be 1.
REQ-020 REQ with dev_ack[k]=1 at an edge SHALL capture dev_rdata channel k into the read register (reads only), drop dev_req on that edge, and go to DONE.
REQ-021 dev_ack bits of unselected channels SHALL be ignored in every state.
REQ-022 A timeout counter, width $clog2(TIMEOUT+1), SHALL clear on entry to REQ and increment each REQ cycle.
REQ-023 When the timeout counter reaches TIMEOUT-1 without dev_ack[k], the FSM SHALL go to DONE:
- read register loads ERR_DATA;
- bus_err pulses 1 for the DONE cycle.
REQ-024 When dev_ack[k] and the timeout occur in the same cycle, the ack SHALL win and no bus_err is raised.
REQ-025 DONE SHALL last exactly one cycle:
- stall = 0;
- cpu_rdata = read register (writes: read register unchanged);
- next state IDLE, unconditionally.
REQ-026 In IDLE on a device region, cpu_rdata SHALL be 0 while stall is 1.
REQ-027 An IDLE cycle with no access SHALL output cpu_rdata = dc_rdata and stall = cache_stall.
REQ-028 Back-to-back device accesses, including to the same address, SHALL each perform a full IDLE-REQ-DONE sequence; minimum 3 cycles per access with an immediate ack.

Reset
REQ-029 rst=0 at an edge SHALL, regardless of state, force:
- state IDLE;
- dev_req = 0, dev_we = 0, dev_addr = 0, dev_wdata = 0, dev_be = 0;
- read register 0, timeout counter 0, bus_err 0.
REQ-030 A reset during REQ SHALL drop dev_req on that edge; any dev_ack arriving afterwards SHALL be ignored.
REQ-031 stall, dc_read, dc_write and cpu_rdata SHALL follow REQ-014/REQ-026/REQ-027 from the first cycle after reset.

Verification
REQ-032 Cache read: addr 30'h0000_0100, cpu_read=1, cache_stall=0, dc_rdata=32'h1234 -> dc_read=1, cpu_rdata=32'h1234 in the same cycle, FSM stays IDLE.
REQ-033 Device write: addr 30'h3000_0004, wdata 32'h41, be 4'b0001 -> stall=1 immediately; next cycle dev_req=4'b0001, dev_addr=26'h4, dev_we=1; ack after 2 cycles -> DONE with stall=0, then IDLE.
REQ-034 Device read on channel 2: region 4'he, dev_rdata[95:64]=32'hcafe, ack immediate -> cpu_rdata=32'hcafe in the DONE cycle, total 3 cycles.
REQ-035 Timeout with TIMEOUT=8, no ack -> REQ lasts 8 cycles, then DONE with cpu_rdata=32'hdeadbeef and bus_err=1 for 1 cycle; with ack in cycle 8 -> ack data and bus_err=0.
REQ-036 Two consecutive writes to the same device address -> two dev_req pulses; a wrong-channel dev_ack is ignored.
REQ-037 rst=0 during REQ -> dev_req=0 at that edge; a later dev_ack is ignored; after reset a cache access passes through.
